sb_alloc_ctrl: RTL and testbench

SB_ALLOC_CTRL -- requirements
Module: sb_alloc_ctrl

---
 rtl/sb_alloc_ctrl.sv | 155 +++++++++++++++
 tb/tb_sb_alloc_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_alloc_ctrl.sv
// sb_alloc_ctrl
// -------------
// Scoreboard allocation controller. Issue is handed in-order transaction
// ids from a circular pool of NR_ENTRIES slots. Writebacks mark slots as
// done in any order. Up to NR_COMMIT_PORTS of the oldest slots retire in
// order once they are done. A flush or a reset empties the whole pool.
//
// Optional feature:
//   SB_ALLOC_CTRL_WB_BYPASS_EN - when defined, a writeback that targets a
//   slot in the current cycle already counts as done for commit, so the
//   slot can retire in the same cycle as its writeback.
//
// Ports:
//   clk_i           clock, all state is rising-edge
//   rst_i           asynchronous active-high reset
//   flush_i         discard every entry at the next edge
//   alloc_valid_i   issue asks for an entry
//   alloc_ready_o   an entry can be granted this cycle
//   alloc_id_o      id granted on the alloc handshake (issue pointer)
//   wb_valid_i      writeback strobe
//   wb_id_i         id being written back
//   commit_valid_o  bit k: slot (commit pointer + k) can retire
//   commit_id_o     slice k: id presented on commit port k
//   commit_ack_i    bit k: commit accepts port k
//   occupancy_o     number of live entries

module sb_alloc_ctrl #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_COMMIT_PORTS = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           alloc_valid_i,
    output logic                           alloc_ready_o,
    output logic [$clog2(NR_ENTRIES)-1:0]  alloc_id_o,
    input  logic                           wb_valid_i,
    input  logic [$clog2(NR_ENTRIES)-1:0]  wb_id_i,
    output logic [NR_COMMIT_PORTS-1:0]     commit_valid_o,
    output logic [NR_COMMIT_PORTS*$clog2(NR_ENTRIES)-1:0] commit_id_o,
    input  logic [NR_COMMIT_PORTS-1:0]     commit_ack_i,
    output logic [$clog2(NR_ENTRIES):0]    occupancy_o
);

    localparam int IDW = $clog2(NR_ENTRIES);

    logic [NR_ENTRIES-1:0]      valid_q;
    logic [NR_ENTRIES-1:0]      done_q;
    logic [NR_ENTRIES-1:0]      valid_d;
    logic [NR_ENTRIES-1:0]      done_d;
    logic [IDW-1:0]             issue_ptr;
    logic [IDW-1:0]             commit_ptr;
    logic [IDW:0]               occupancy;
    logic                       alloc_fire;
    logic [IDW-1:0]             head_idx [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] commit_valid;
    logic [NR_COMMIT_PORTS-1:0] retire_mask;
    logic [IDW:0]               retire_cnt;

    // Ready comes from registered occupancy only, so a commit in the same
    // cycle never opens up a slot early. Reset holds it low.
    assign alloc_ready_o = !rst_i && !flush_i
                           && (occupancy < (IDW+1)'(NR_ENTRIES));
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign alloc_id_o    = issue_ptr;
    assign occupancy_o   = occupancy;
    assign commit_valid_o = commit_valid;

    // Slot index seen by each commit port, wrapping naturally in IDW bits.
    always_comb begin
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            head_idx[k] = commit_ptr + IDW'(k);
            commit_id_o[k*IDW +: IDW] = head_idx[k];
        end
    end

    // A port is retirable only if every older port is retirable too, so
    // the valid vector is always a prefix of ones.
    always_comb begin
        logic run;
        logic entry_done;
        run          = 1'b1;
        entry_done   = 1'b0;
        commit_valid = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            entry_done = done_q[head_idx[k]];
`ifdef SB_ALLOC_CTRL_WB_BYPASS_EN
            entry_done = entry_done
                         || (wb_valid_i && (wb_id_i == head_idx[k]));
`endif
            run = run && valid_q[head_idx[k]] && entry_done;
            commit_valid[k] = run;
        end
    end

    // Only the leading run of accepted ports retires; an ack after the
    // first gap is dropped so retirement stays strictly in order.
    always_comb begin
        logic run;
        run         = 1'b1;
        retire_mask = '0;
        retire_cnt  = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            run = run && commit_ack_i[k] && commit_valid[k];
            retire_mask[k] = run;
            retire_cnt = retire_cnt + (IDW+1)'(run);
        end
    end

    // Per-slot next state. Writeback only lands on live slots, retire
    // clears the slot, and a fresh alloc claims the slot under the issue
    // pointer. The allocated slot is never live, so it cannot collide with
    // a writeback or a retire in the same cycle.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (wb_valid_i && valid_q[wb_id_i]) begin
            done_d[wb_id_i] = 1'b1;
        end
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (retire_mask[k]) begin
                valid_d[head_idx[k]] = 1'b0;
                done_d[head_idx[k]]  = 1'b0;
            end
        end
        if (alloc_fire) begin
            valid_d[issue_ptr] = 1'b1;
            done_d[issue_ptr]  = 1'b0;
        end
    end

    // State registers. Flush wins over every same-cycle request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            done_q     <= '0;
            issue_ptr  <= '0;
            commit_ptr <= '0;
            occupancy  <= '0;
        end else if (flush_i) begin
            valid_q    <= '0;
            done_q     <= '0;
            issue_ptr  <= '0;
            commit_ptr <= '0;
            occupancy  <= '0;
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            issue_ptr  <= issue_ptr + IDW'(alloc_fire);
            commit_ptr <= commit_ptr + retire_cnt[IDW-1:0];
            occupancy  <= occupancy + (IDW+1)'(alloc_fire) - retire_cnt;
        end
    end

endmodule

// File: tb/tb_sb_alloc_ctrl.sv
// Testbench for sb_alloc_ctrl (NR_ENTRIES=8, NR_COMMIT_PORTS=2).
// A queue-based model of live ids tracks expected outputs every cycle;
// a vector table and short directed sequences cover the corner cases,
// followed by a randomized run.

module tb_sb_alloc_ctrl;

    localparam int N   = 8;
    localparam int P   = 2;
    localparam int IDW = 3;

`ifdef SB_ALLOC_CTRL_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [IDW-1:0]   alloc_id;
    logic             wb_valid;
    logic [IDW-1:0]   wb_id;
    logic [P-1:0]     commit_valid;
    logic [P*IDW-1:0] commit_id;
    logic [P-1:0]     commit_ack;
    logic [IDW:0]     occupancy;

    int passed = 0;
    int total  = 0;

    // Reference model: ordered list of live ids plus a done flag per id.
    int live_q[$];
    bit done_m [N];
    int next_id;

    // Values sampled by the most recent applyStimulus call.
    int s_ready, s_id, s_occ, s_cv, s_cid;

    typedef struct {
        bit         alloc;
        bit         wb;
        int         wbid;
        logic [1:0] ack;
        int         ready;
        int         id;
        int         occ;
        int         cv;
    } vec_t;

    vec_t vecs [13];

    sb_alloc_ctrl #(.NR_ENTRIES(N), .NR_COMMIT_PORTS(P)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .alloc_valid_i  (alloc_valid),
        .alloc_ready_o  (alloc_ready),
        .alloc_id_o     (alloc_id),
        .wb_valid_i     (wb_valid),
        .wb_id_i        (wb_id),
        .commit_valid_o (commit_valid),
        .commit_id_o    (commit_id),
        .commit_ack_i   (commit_ack),
        .occupancy_o    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        live_q.delete();
        foreach (done_m[i]) done_m[i] = 1'b0;
        next_id = 0;
    endtask

    // Called just after a rising edge: drive inputs, compare every output
    // against the model mid-cycle, then advance the model across the edge.
    task automatic applyStimulus(input bit f, input bit a, input bit w,
                                 input int wid, input logic [1:0] ack);
        int   e_ready, e_occ, e_cv, e_cid, head, n, junk;
        bit   run, d, is_live;
        flush       = f;
        alloc_valid = a;
        wb_valid    = w;
        wb_id       = IDW'(wid);
        commit_ack  = ack;
        #4;
        e_occ   = live_q.size();
        e_ready = (e_occ < N && !f) ? 1 : 0;
        head    = (next_id - e_occ + N) % N;
        e_cv    = 0;
        e_cid   = 0;
        run     = 1'b1;
        for (int k = 0; k < P; k++) begin
            if (k < live_q.size()) begin
                d   = done_m[live_q[k]] || (BYP && w && (wid == live_q[k]));
                run = run && d;
            end else begin
                run = 1'b0;
            end
            if (run) e_cv |= (1 << k);
            e_cid |= (((head + k) % N) << (k * IDW));
        end
        s_ready = int'(alloc_ready);
        s_id    = int'(alloc_id);
        s_occ   = int'(occupancy);
        s_cv    = int'(commit_valid);
        s_cid   = int'(commit_id);
        checkOutput("alloc_ready", s_ready, e_ready);
        checkOutput("alloc_id",    s_id,    next_id);
        checkOutput("occupancy",   s_occ,   e_occ);
        checkOutput("commit_valid", s_cv,   e_cv);
        checkOutput("commit_id",   s_cid,   e_cid);
        @(posedge clk);
        if (f) begin
            modelReset();
        end else begin
            is_live = 1'b0;
            foreach (live_q[i]) if (live_q[i] == wid) is_live = 1'b1;
            if (w && is_live) done_m[wid] = 1'b1;
            n = 0;
            for (int k = 0; k < P; k++) begin
                if (n == k && e_cv[k] && ack[k]) n++;
            end
            for (int k = 0; k < n; k++) begin
                junk = live_q.pop_front();
                done_m[junk] = 1'b0;
            end
            if (a && e_ready == 1) begin
                live_q.push_back(next_id);
                done_m[next_id] = 1'b0;
                next_id = (next_id + 1) % N;
            end
        end
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        #4;
        checkOutput({tag, "_ready"}, int'(alloc_ready), 0);
        checkOutput({tag, "_id"},    int'(alloc_id),    0);
        checkOutput({tag, "_occ"},   int'(occupancy),   0);
        checkOutput({tag, "_cv"},    int'(commit_valid), 0);
    endtask

    initial begin
        int f, a, w, wid, ack;

        // Reset release, back-to-back allocs, out-of-order writeback.
        for (int i = 0; i < 8; i++) vecs[i] = '{1, 0, 0, 2'b00, 1, i, i, 0};
        vecs[8]  = '{0, 0, 0, 2'b00, 0, 0, 8, 0};
        vecs[9]  = '{0, 1, 1, 2'b00, 0, 0, 8, 0};
        vecs[10] = '{0, 1, 0, 2'b11, 0, 0, 8, BYP ? 3 : 0};
        vecs[11] = '{0, 0, 0, 2'b11, BYP ? 1 : 0, 0, BYP ? 6 : 8, BYP ? 0 : 3};
        vecs[12] = '{0, 0, 0, 2'b00, 1, 0, 6, 0};

        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
        wb_id = '0; commit_ack = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, vecs[i].alloc, vecs[i].wb, vecs[i].wbid, vecs[i].ack);
            checkOutput($sformatf("vec%0d_ready", i), s_ready, vecs[i].ready);
            checkOutput($sformatf("vec%0d_id", i),    s_id,    vecs[i].id);
            checkOutput($sformatf("vec%0d_occ", i),   s_occ,   vecs[i].occ);
            checkOutput($sformatf("vec%0d_cv", i),    s_cv,    vecs[i].cv);
        end

        // Non-prefix ack: ack only port 1 while both are valid.
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 3, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b10);
        checkOutput("nonprefix_cv", s_cv, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b00);
        checkOutput("nonprefix_occ", s_occ, 6);
        checkOutput("nonprefix_head", s_cid & 7, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b11);

        // Wrap-around: move the commit pointer to 7, then retire 7 and 0.
        applyStimulus(1'b0, 1'b0, 1'b1, 4, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 5, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 6, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b11);
        checkOutput("wrap_partial_cv", s_cv, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 7, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b00);
        checkOutput("wrap_cv", s_cv, 3);
        checkOutput("wrap_cid", s_cid, 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b00);
        checkOutput("wrap_head", s_cid & 7, 1);
        checkOutput("wrap_occ", s_occ, 0);

        // Flush contention on 5 live entries.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, 3, 2'b11);
        checkOutput("flush_ready", s_ready, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b00);
        checkOutput("flush_occ", s_occ, 0);
        checkOutput("flush_id", s_id, 0);
        checkOutput("flush_cv", s_cv, 0);

        // Writeback-to-commit latency on the head entry.
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 2'b00);
        checkOutput("latency_same_cycle", s_cv & 1, BYP ? 1 : 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b00);
        checkOutput("latency_next_cycle", s_cv & 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b00);
        checkOutput("latency_retired", s_occ, 0);

        // Reset in the middle of operation.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 2'b00);
        rst = 1'b1;
        alloc_valid = 1'b1;
        wb_valid = 1'b1;
        commit_ack = 2'b11;
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 2'b11);
        checkOutput("midreset_release_ready", s_ready, 1);
        checkOutput("midreset_release_occ", s_occ, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            f = ($urandom_range(0, 59) == 0) ? 1 : 0;
            a = ($urandom_range(0, 3) != 0) ? 1 : 0;
            w = $urandom_range(0, 1);
            if (live_q.size() > 0 && $urandom_range(0, 3) != 0)
                wid = live_q[$urandom_range(0, live_q.size() - 1)];
            else
                wid = $urandom_range(0, N - 1);
            ack = $urandom_range(0, 3);
            applyStimulus(f[0], a[0], w[0], wid, ack[1:0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
